// File: rtl/glb_stream_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | glb_stream_pkg - shared types and helpers for the GLB stream source        |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package glb_stream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } glb_src_state_e;

  localparam logic CTRL_DATA  = 1'b0;
  localparam logic CTRL_TOKEN = 1'b1;

  // Address step with natural power-of-two wrap at aw bits.
  function automatic logic [31:0] stride_add(input logic [31:0] addr,
                                             input logic [31:0] stride,
                                             input int unsigned aw);
    return (addr + stride) & ((32'd1 << aw) - 32'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/glb_src_skid.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | glb_src_skid - 2-entry ready/valid skid buffer with synchronous clear      |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module glb_src_skid
  import glb_stream_pkg::*;
#(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic [1:0]   count,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [W-1:0] head;
  logic [W-1:0] tail;
  logic         pop;

  assign pop       = out_valid && out_ready;
  assign out_valid = (count != 2'd0);
  assign out_data  = head;

  // The producer only pushes when space is guaranteed, so no in_ready is needed.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else begin
      case ({in_valid, pop})
        2'b10: begin
          if (count == 2'd0) head <= in_data;
          else               tail <= in_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd2) begin
            head <= tail;
            tail <= in_data;
          end else begin
            head <= in_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/glb_stream_src.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | glb_stream_src - strided, repeating GLB stream source (opt. GLB_STREAM_EOS_EN) |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module glb_stream_src
  import glb_stream_pkg::*;
#(
  parameter  int DATA_W = 16,
  parameter  int DEPTH  = 1024,
  localparam int AW     = $clog2(DEPTH),
  parameter  int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              ld_en,
  input  logic [AW-1:0]     ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [AW-1:0]     cfg_start_addr,
  input  logic [AW-1:0]     cfg_stride,
  input  logic [CNT_W-1:0]  cfg_tx_size,
  input  logic [CNT_W-1:0]  cfg_repeat,
  output logic [DATA_W:0]   data,
  output logic              valid,
  input  logic              ready,
  output logic              done
);

  glb_src_state_e    state_q, state_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W:0]   skid_in;
  logic [1:0]        skid_cnt;
  logic [AW-1:0]     start_q, stride_q, addr_q, next_addr;
  logic [CNT_W-1:0]  tx_q, rep_q, wcnt_q, pass_q;
  logic              rd_v, reads_done, all_issued;
  logic              pop, room, last_beat;
  logic              capture, issue, abort, set_done, clr_done;
`ifdef GLB_STREAM_EOS_EN
  logic              tok_issue, tok_sent, rd_tok;
`endif

  assign next_addr = AW'(stride_add(32'(addr_q), 32'(stride_q), AW));
  assign pop       = valid && ready;
  // One read in flight plus skid contents must never exceed the two skid slots.
  assign room      = ({1'b0, skid_cnt} + {2'b00, rd_v}) <= (3'd1 + {2'b00, pop});
`ifdef GLB_STREAM_EOS_EN
  assign all_issued = tok_sent;
  assign skid_in    = rd_tok ? {CTRL_TOKEN, {DATA_W{1'b0}}} : {CTRL_DATA, rd_word};
`else
  assign all_issued = reads_done;
  assign skid_in    = {CTRL_DATA, rd_word};
`endif
  assign last_beat = all_issued && !rd_v &&
                     ((skid_cnt == 2'd0) || (pop && skid_cnt == 2'd1));

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    issue    = 1'b0;
    abort    = 1'b0;
    set_done = 1'b0;
    clr_done = 1'b0;
`ifdef GLB_STREAM_EOS_EN
    tok_issue = 1'b0;
`endif
    case (state_q)
      IDLE:  if (flush) state_d = ARMED;
      ARMED: if (!flush) begin
        state_d = STREAM;
        capture = 1'b1;
      end
      STREAM: begin
        if (flush) begin
          state_d = ARMED;
          abort   = 1'b1;
        end else begin
          if (room && !reads_done) issue = 1'b1;
`ifdef GLB_STREAM_EOS_EN
          else if (room && !tok_sent) tok_issue = 1'b1;
`endif
          if (last_beat) begin
            state_d  = DONE;
            set_done = 1'b1;
          end
        end
      end
      DONE: if (flush) begin
        state_d  = ARMED;
        clr_done = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      start_q    <= '0;
      stride_q   <= '0;
      tx_q       <= '0;
      rep_q      <= '0;
      addr_q     <= '0;
      wcnt_q     <= '0;
      pass_q     <= '0;
      reads_done <= 1'b0;
      rd_v       <= 1'b0;
      done       <= 1'b0;
`ifdef GLB_STREAM_EOS_EN
      tok_sent   <= 1'b0;
      rd_tok     <= 1'b0;
`endif
    end else begin
`ifdef GLB_STREAM_EOS_EN
      rd_v   <= issue || tok_issue;
      rd_tok <= tok_issue;
      if (capture)        tok_sent <= 1'b0;
      else if (tok_issue) tok_sent <= 1'b1;
`else
      rd_v <= issue;
`endif
      if (capture) begin
        start_q    <= cfg_start_addr;
        stride_q   <= cfg_stride;
        tx_q       <= cfg_tx_size;
        rep_q      <= cfg_repeat;
        addr_q     <= cfg_start_addr;
        wcnt_q     <= '0;
        pass_q     <= '0;
        reads_done <= (cfg_tx_size == '0);
      end else if (issue) begin
        if (wcnt_q == tx_q - CNT_W'(1)) begin
          wcnt_q <= '0;
          addr_q <= start_q;
          pass_q <= pass_q + CNT_W'(1);
          if (pass_q == rep_q) reads_done <= 1'b1;
        end else begin
          wcnt_q <= wcnt_q + CNT_W'(1);
          addr_q <= next_addr;
        end
      end
      if (set_done)      done <= 1'b1;
      else if (clr_done) done <= 1'b0;
    end
  end

  // Buffer keeps its contents through reset; loads are blocked while streaming.
  always_ff @(posedge clk) begin
    if (ld_en && state_q != STREAM) mem[ld_addr] <= ld_data;
    if (issue) rd_word <= mem[addr_q];
  end

  glb_src_skid #(.W(DATA_W + 1)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (abort),
    .in_valid  (rd_v),
    .in_data   (skid_in),
    .count     (skid_cnt),
    .out_valid (valid),
    .out_ready (ready),
    .out_data  (data)
  );

endmodule
`default_nettype wire

// File: tb/tb_glb_stream_src.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_glb_stream_src - directed table-driven bench for glb_stream_src         |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_glb_stream_src;

`ifdef GLB_STREAM_EOS_EN
  localparam bit EOS = 1'b1;
`else
  localparam bit EOS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        ld_en = 1'b0;
  logic [9:0]  ld_addr = '0;
  logic [15:0] ld_data = '0;
  logic [9:0]  cfg_start_addr = '0;
  logic [9:0]  cfg_stride = '0;
  logic [15:0] cfg_tx_size = '0;
  logic [15:0] cfg_repeat = '0;
  logic [16:0] data;
  logic        valid;
  logic        ready = 1'b0;
  logic        done;

  glb_stream_src dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .ld_en          (ld_en),
    .ld_addr        (ld_addr),
    .ld_data        (ld_data),
    .cfg_start_addr (cfg_start_addr),
    .cfg_stride     (cfg_stride),
    .cfg_tx_size    (cfg_tx_size),
    .cfg_repeat     (cfg_repeat),
    .data           (data),
    .valid          (valid),
    .ready          (ready),
    .done           (done)
  );

  always #5 clk = ~clk;

  // mode: 0 = ready always, 1 = ready toggling 1,0, 2 = random ready
  typedef struct {
    int start;
    int stride;
    int tx;
    int rep;
    int mode;
    bit wr;
    int exp_beats;
    int exp_sum;
  } vec_t;

  vec_t        tbl[8];
  logic [15:0] model_mem [1024];
  int          vectors = 0;
  int          errors = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int model_word(input vec_t v, input int b);
    int tot;
    int a;
    tot = v.tx * (v.rep + 1);
    if (b >= tot) return 32'h10000;
    a = (v.start + (b % v.tx) * v.stride) % 1024;
    return int'(model_mem[a]);
  endfunction

  // Leaves the bench just after T0 (flush sampled low in ARMED).
  task automatic begin_stream(input vec_t v);
    cfg_start_addr = 10'(v.start);
    cfg_stride     = 10'(v.stride);
    cfg_tx_size    = 16'(v.tx);
    cfg_repeat     = 16'(v.rep);
    ready = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
  endtask

  task automatic collect(input vec_t v);
    int   beats, cyc, sum, exp_total, exp_sum;
    bit   seen;
    logic pv, pr;
    logic [16:0] pd;
    beats = 0; cyc = 0; sum = 0; seen = 1'b0;
    exp_total = v.exp_beats + (EOS ? 1 : 0);
    exp_sum   = v.exp_sum + (EOS ? 32'h10000 : 0);
    while (!done && cyc < 600) begin
      case (v.mode)
        0:       ready = 1'b1;
        1:       ready = (cyc % 2 == 0);
        default: ready = 1'($urandom_range(0, 1));
      endcase
      if (v.wr && cyc == 3) begin
        ld_en = 1'b1; ld_addr = 10'd2; ld_data = 16'hFFFF;
      end
      pv = valid; pd = data; pr = ready;
      step();
      ld_en = 1'b0;
      cyc++;
      if (pv && pr) begin
        check("beat_data", int'(pd), model_word(v, beats));
        beats++;
        sum += int'(pd);
        if (beats == exp_total) begin
          check("valid_after_last", int'(valid), 0);
          check("done_after_last", int'(done), 1);
        end else begin
          check("done_early", int'(done), 0);
        end
      end else if (pv) begin
        check("hold_data", int'(data), int'(pd));
        check("hold_valid", int'(valid), 1);
      end
      if (valid && !seen) begin
        seen = 1'b1;
        check("first_valid_latency", cyc, 2);
      end
    end
    ready = 1'b0;
    check("beat_count", beats, exp_total);
    check("beat_sum", sum, exp_sum);
    check("done_final", int'(done), 1);
    if (exp_total == 0) check("tx0_done_time", cyc, 1);
  endtask

  task automatic run_row(input vec_t v);
    begin_stream(v);
    collect(v);
  endtask

  initial begin
    vec_t v;
    int   beats;
    int   guard;

    tbl[0] = '{0,    1, 32, 0, 0, 1'b1, 32, 496};
    tbl[1] = '{0,    1, 32, 0, 1, 1'b0, 32, 496};
    tbl[2] = '{1020, 3, 4,  0, 0, 1'b0, 4,  2050};
    tbl[3] = '{8,    1, 3,  2, 0, 1'b0, 9,  81};
    tbl[4] = '{5,    0, 4,  0, 1, 1'b0, 4,  20};
    tbl[5] = '{0,    1, 0,  0, 0, 1'b0, 0,  0};
    tbl[6] = '{100,  7, 5,  1, 2, 1'b0, 10, 1140};
    tbl[7] = '{0,    1, 2,  0, 0, 1'b0, 2,  1};

    rst_n = 1'b0;
    step();
    step();
    check("reset_valid", int'(valid), 0);
    check("reset_data", int'(data), 0);
    check("reset_done", int'(done), 0);
    rst_n = 1'b1;

    for (int a = 0; a < 1024; a++) begin
      ld_en = 1'b1; ld_addr = 10'(a); ld_data = 16'(a);
      model_mem[a] = 16'(a);
      step();
    end
    ld_en = 1'b0;
    step();

    for (int i = 0; i < 8; i++) run_row(tbl[i]);

    repeat (3) step();
    check("done_sticky", int'(done), 1);

    // load while DONE is accepted
    ld_en = 1'b1; ld_addr = 10'd50; ld_data = 16'hBEEF;
    model_mem[50] = 16'hBEEF;
    step();
    ld_en = 1'b0;
    v = '{50, 0, 1, 0, 0, 1'b0, 1, 32'hBEEF};
    run_row(v);

    // abort after 5 beats, then the stream replays from word 0
    begin_stream(tbl[0]);
    beats = 0; guard = 0;
    ready = 1'b1;
    while (beats < 5 && guard < 100) begin
      if (valid) beats++;
      step();
      guard++;
    end
    check("abort_reach_beat5", beats, 5);
    ready = 1'b0;
    flush = 1'b1;
    step();
    check("abort_valid", int'(valid), 0);
    check("abort_done", int'(done), 0);
    flush = 1'b0;
    step();
    collect(tbl[0]);

    // reset mid-stream
    begin_stream(tbl[0]);
    ready = 1'b1;
    repeat (4) step();
    rst_n = 1'b0;
    step();
    check("rst_mid_valid", int'(valid), 0);
    check("rst_mid_data", int'(data), 0);
    check("rst_mid_done", int'(done), 0);
    rst_n = 1'b1;
    ready = 1'b0;
    step();
    run_row(tbl[2]);
    run_row(v);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
